// File: rtl/wallace_pkg.sv
// Shared definitions for the Wallace-tree dot-product accumulator.
//   OP_W   : operand width of the multiplier (4)
//   PROD_W : product width (8)
//   clog2  : index width helper, never returns less than 1
//   full_add / half_add : bit-level reduction cells used by the tree,
//                         returning {carry, sum}
package wallace_pkg;

    localparam int OP_W   = 4;
    localparam int PROD_W = 8;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return (r < 1) ? 1 : r;
    endfunction

    function automatic logic [1:0] full_add(input logic x, input logic y, input logic z);
        return {(x & y) | (x & z) | (y & z), x ^ y ^ z};
    endfunction

    function automatic logic [1:0] half_add(input logic x, input logic y);
        return {x & y, x ^ y};
    endfunction

endpackage

// File: rtl/wallace_dot_accum_if.sv
// Handshake bundle between an operand producer / result consumer and
// wallace_dot_accum.
//   in_valid/in_ready/a/b       : operand pair stream into the block
//   out_valid/out_ready/result  : completed dot-product stream out of the block
//   term_idx                    : index of the next term the block will accept
// Modports: master = producer/consumer side, slave = the accumulator.
interface wallace_dot_accum_if
    import wallace_pkg::*;
#(
    parameter int LEN   = 4,
    parameter int ACC_W = 12
);
    localparam int IDX_W = clog2(LEN);

    logic             in_valid;
    logic             in_ready;
    logic [OP_W-1:0]  a;
    logic [OP_W-1:0]  b;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] result;
    logic [IDX_W-1:0] term_idx;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, result, term_idx
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, result, term_idx
    );

endinterface

// File: rtl/wallace_Multiplier.sv
// Combinational 4x4 unsigned Wallace-tree multiplier.
//   a, b : 4-bit operands
//   pro  : 8-bit product
// Two layers of full/half adders reduce the four partial-product rows to a
// sum row and a carry row, which a final carry-propagate add combines.
// The reduction wiring is specific to 4-bit operands.
module wallace_Multiplier
    import wallace_pkg::*;
(
    input  logic [OP_W-1:0]   a,
    input  logic [OP_W-1:0]   b,
    output logic [PROD_W-1:0] pro
);

    // pp[i] is row i (weight 2^i): a AND b[i]
    logic [OP_W-1:0] pp [OP_W];

    generate
        for (genvar gi = 0; gi < OP_W; gi++) begin : g_pp
            assign pp[gi] = a & {OP_W{b[gi]}};
        end
    endgenerate

    // Layer 1: reduce rows 0..2; row 3 passes through.
    logic [1:0] s1_h1, s1_f2, s1_f3, s1_h4;
    // Layer 2: reduce layer-1 sum row, layer-1 carry row and row 3.
    logic [1:0] s2_h2, s2_f3, s2_f4, s2_f5;
    logic [PROD_W-1:0] sum_row, carry_row;

    always_comb begin
        s1_h1 = half_add(pp[0][1], pp[1][0]);                 // weight 1
        s1_f2 = full_add(pp[0][2], pp[1][1], pp[2][0]);       // weight 2
        s1_f3 = full_add(pp[0][3], pp[1][2], pp[2][1]);       // weight 3
        s1_h4 = half_add(pp[1][3], pp[2][2]);                 // weight 4

        s2_h2 = half_add(s1_f2[0], s1_h1[1]);                 // weight 2
        s2_f3 = full_add(s1_f3[0], s1_f2[1], pp[3][0]);       // weight 3
        s2_f4 = full_add(s1_h4[0], s1_f3[1], pp[3][1]);       // weight 4
        s2_f5 = full_add(pp[2][3], s1_h4[1], pp[3][2]);       // weight 5

        sum_row   = {1'b0, pp[3][3], s2_f5[0], s2_f4[0], s2_f3[0],
                     s2_h2[0], s1_h1[0], pp[0][0]};
        carry_row = {1'b0, s2_f5[1], s2_f4[1], s2_f3[1], s2_h2[1], 3'b000};
        pro       = sum_row + carry_row;
    end

endmodule

// File: rtl/wallace_dot_accum.sv
// Dot-product accumulator built around one wallace_Multiplier.
// Accepts LEN operand pairs per vector, registers each product (stage 1),
// accumulates them (stage 2) and presents the sum on a valid/ready port.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : wallace_dot_accum_if.slave (operand in, result out, term_idx)
// Optional: define WALLACE_DOT_SAT_EN to saturate the accumulator at
// 2^ACC_W-1 (sticky within a vector) instead of wrapping.
module wallace_dot_accum
    import wallace_pkg::*;
#(
    parameter int LEN   = 4,
    parameter int ACC_W = 12
)(
    input  logic clk,
    input  logic rst_n,
    wallace_dot_accum_if.slave bus
);

    localparam int IDX_W = clog2(LEN);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LEN - 1);

    logic [PROD_W-1:0] prod;

    wallace_Multiplier u_mult (
        .a   (bus.a),
        .b   (bus.b),
        .pro (prod)
    );

    logic [PROD_W-1:0] p_reg_q, p_reg_d;
    logic              p_vld_q, p_vld_d;
    logic              p_first_q, p_first_d;
    logic              p_last_q, p_last_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [ACC_W-1:0]  result_q, result_d;
    logic              out_valid_q, out_valid_d;
`ifdef WALLACE_DOT_SAT_EN
    logic              sat_q, sat_d;
    logic [ACC_W:0]    sum_wide;
    logic              sat_now;
`endif

    logic             stall, accept, fire;
    logic [ACC_W-1:0] base, sum;

    // A finished vector waiting in stage 1 cannot overwrite a result the
    // consumer has not taken yet, so the whole pipe freezes.
    assign stall  = p_vld_q && p_last_q && out_valid_q && !bus.out_ready;
    assign accept = bus.in_valid && !stall;
    assign fire   = p_vld_q && !stall;

    always_comb begin
        p_reg_d     = p_reg_q;
        p_vld_d     = p_vld_q;
        p_first_d   = p_first_q;
        p_last_d    = p_last_q;
        idx_d       = idx_q;
        acc_d       = acc_q;
        result_d    = result_q;
        out_valid_d = out_valid_q;

        // Stage 1
        if (!stall) begin
            p_vld_d = accept;
            if (accept) begin
                p_reg_d   = prod;
                p_first_d = (idx_q == '0);
                p_last_d  = (idx_q == LAST_IDX);
                idx_d     = (idx_q == LAST_IDX) ? '0 : IDX_W'(idx_q + 1'b1);
            end
        end

        // Stage 2: the first term of a vector restarts from zero, which lets
        // a new vector follow the previous one without a bubble.
        base = p_first_q ? '0 : acc_q;
`ifdef WALLACE_DOT_SAT_EN
        sat_d    = sat_q;
        sum_wide = {1'b0, base} + (ACC_W + 1)'(p_reg_q);
        sat_now  = sum_wide[ACC_W] || (sat_q && !p_first_q);
        sum      = sat_now ? '1 : sum_wide[ACC_W-1:0];
`else
        sum      = base + ACC_W'(p_reg_q);
`endif

        if (fire) begin
            acc_d = sum;
`ifdef WALLACE_DOT_SAT_EN
            sat_d = sat_now;
`endif
        end

        // Output register: a new result can replace one being consumed.
        if (fire && p_last_q) begin
            result_d    = sum;
            out_valid_d = 1'b1;
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_reg_q     <= '0;
            p_vld_q     <= 1'b0;
            p_first_q   <= 1'b0;
            p_last_q    <= 1'b0;
            idx_q       <= '0;
            acc_q       <= '0;
            result_q    <= '0;
            out_valid_q <= 1'b0;
`ifdef WALLACE_DOT_SAT_EN
            sat_q       <= 1'b0;
`endif
        end else begin
            p_reg_q     <= p_reg_d;
            p_vld_q     <= p_vld_d;
            p_first_q   <= p_first_d;
            p_last_q    <= p_last_d;
            idx_q       <= idx_d;
            acc_q       <= acc_d;
            result_q    <= result_d;
            out_valid_q <= out_valid_d;
`ifdef WALLACE_DOT_SAT_EN
            sat_q       <= sat_d;
`endif
        end
    end

    assign bus.in_ready  = !stall;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.term_idx  = idx_q;

endmodule
